// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the unipolar stepper: accepts move commands and steps the 8-phase
// half-step coil pattern at the commanded rate. Define STEPPER_RAMP_EN for trapezoid ramping.
module stepper_move_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned MIN_PERIOD = 50000,
    parameter int unsigned RAMP_START = 500000,
    parameter int unsigned RAMP_STEP  = 10000
) (
    input  logic              CLK50MHZ,
    input  logic              RSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [CNT_W-1:0]  cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    output logic [3:0]        coil,
    output logic              busy,
    output logic              done,
    output logic [31:0]       position
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [DIV_W-1:0] MinPeriod = DIV_W'(MIN_PERIOD);

    state_t             state_q, state_d;
    logic [2:0]         index_q, index_d;
    logic [3:0]         coil_q, coil_d;
    logic [31:0]        position_q, position_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [DIV_W-1:0]   timer_q, timer_d;

    logic [DIV_W-1:0]   eff_cmd;
    logic [DIV_W-1:0]   step_period;
    logic [2:0]         index_next;
    logic               step_now;

    function automatic logic [3:0] phase(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b0100;
            3'd1:    pat = 4'b0110;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b1010;
            3'd4:    pat = 4'b1000;
            3'd5:    pat = 4'b1001;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b0101;
        endcase
        return pat;
    endfunction

    assign eff_cmd    = (cmd_period < MinPeriod) ? MinPeriod : cmd_period;
    assign index_next = dir_q ? (index_q + 3'd1) : (index_q - 3'd1);

`ifdef STEPPER_RAMP_EN
    localparam logic [DIV_W-1:0] RampStart = DIV_W'(RAMP_START);
    localparam logic [DIV_W-1:0] RampStep  = DIV_W'(RAMP_STEP);

    logic [DIV_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]   accel_q, accel_d;
    logic [DIV_W-1:0]   ramp_cap;
    logic [DIV_W:0]     ramp_up;
    logic [CNT_W-1:0]   rem_after;

    assign step_period = cur_q;
    // Decel ceiling never drops below the commanded period for slow moves.
    assign ramp_cap    = (period_q > RampStart) ? period_q : RampStart;
    assign ramp_up     = {1'b0, cur_q} + {1'b0, RampStep};
    assign rem_after   = remaining_q - CNT_W'(1);
`else
    assign step_period = period_q;
`endif

    assign step_now = (state_q == StRun) && (timer_q == step_period - DIV_W'(1));

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        coil_d      = coil_q;
        position_d  = position_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        timer_d     = timer_q;
`ifdef STEPPER_RAMP_EN
        cur_d       = cur_q;
        accel_d     = accel_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    dir_d       = cmd_dir;
                    remaining_d = cmd_steps;
                    period_d    = eff_cmd;
                    timer_d     = '0;
`ifdef STEPPER_RAMP_EN
                    cur_d       = (eff_cmd > RampStart) ? eff_cmd : RampStart;
                    accel_d     = '0;
`endif
                    if (cmd_steps == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        coil_d  = phase(index_q);
                    end
                end
            end
            StRun: begin
                if (step_now) begin
                    index_d     = index_next;
                    coil_d      = phase(index_next);
                    position_d  = dir_q ? (position_q + 32'd1) : (position_q - 32'd1);
                    remaining_d = remaining_q - CNT_W'(1);
                    timer_d     = '0;
`ifdef STEPPER_RAMP_EN
                    if (rem_after <= accel_q) begin
                        cur_d = (ramp_up >= {1'b0, ramp_cap}) ? ramp_cap : ramp_up[DIV_W-1:0];
                    end else if (cur_q > period_q) begin
                        cur_d   = ((cur_q - period_q) > RampStep) ? (cur_q - RampStep) : period_q;
                        accel_d = accel_q + CNT_W'(1);
                    end
`endif
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end else begin
                    timer_d = timer_q + DIV_W'(1);
                end
                // A step coinciding with abort is still taken above.
                if (abort) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= StIdle;
            index_q     <= '0;
            coil_q      <= '0;
            position_q  <= '0;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            period_q    <= MinPeriod;
            timer_q     <= '0;
`ifdef STEPPER_RAMP_EN
            cur_q       <= '0;
            accel_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            coil_q      <= coil_d;
            position_q  <= position_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            timer_q     <= timer_d;
`ifdef STEPPER_RAMP_EN
            cur_q       <= cur_d;
            accel_q     <= accel_d;
`endif
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign coil      = coil_q;
    assign position  = position_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl; MIN_PERIOD is scaled down to 50 clocks to keep runs short.
module tb_stepper_move_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DIV_W = 24;

    logic             CLK50MHZ = 1'b0;
    logic             RSTN;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_period;
    logic             abort;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [31:0]      position;

    int errors = 0;
    int checks = 0;

    stepper_move_ctrl #(
        .CNT_W      (CNT_W),
        .DIV_W      (DIV_W),
        .MIN_PERIOD (50),
        .RAMP_START (500),
        .RAMP_STEP  (10)
    ) dut (
        .CLK50MHZ   (CLK50MHZ),
        .RSTN       (RSTN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .coil       (coil),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        #2;
        RSTN = 1'b1;
        tick();
    endtask

    task automatic offer(input logic dir, input int steps, input int period);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = CNT_W'(steps);
        cmd_period = DIV_W'(period);
    endtask

    logic [3:0] fwd [8];
    logic [3:0] rev [3];
    logic [3:0] prev;

    initial begin
        fwd = '{4'b0110, 4'b0010, 4'b1010, 4'b1000, 4'b1001, 4'b0001, 4'b0101, 4'b0100};
        rev = '{4'b0101, 4'b0001, 4'b1001};
        RSTN = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_steps = '0;
        cmd_period = '0;
        abort = 1'b0;
        ticks(3);
        chk("rst_coil", 32'(coil), 32'h0);
        chk("rst_pos", position, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        RSTN = 1'b1;
        tick();

        // Forward 8 half-steps, one full electrical cycle.
        offer(1'b1, 8, 50);
        tick();
        cmd_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_ready", 32'(cmd_ready), 32'h0);
        chk("t1_energise", 32'(coil), 32'h4);
        prev = 4'b0100;
        for (int n = 0; n < 8; n++) begin
            ticks(49);
            chk("t1_hold", 32'(coil), 32'(prev));
            tick();
            chk("t1_step", 32'(coil), 32'(fwd[n]));
            prev = fwd[n];
        end
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_off", 32'(busy), 32'h0);
        chk("t1_pos", position, 32'd8);
        tick();
        chk("t1_done_pulse", 32'(done), 32'h0);
        chk("t1_ready_back", 32'(cmd_ready), 32'h1);
        chk("t1_final_coil", 32'(coil), 32'h4);

        // Reverse 3 with a period below the clamp.
        do_reset();
        offer(1'b0, 3, 10);
        tick();
        cmd_valid = 1'b0;
        chk("t2_energise", 32'(coil), 32'h4);
        prev = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            ticks(49);
            chk("t2_hold", 32'(coil), 32'(prev));
            tick();
            chk("t2_step", 32'(coil), 32'(rev[n]));
            prev = rev[n];
        end
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_pos", position, 32'hFFFF_FFFD);
        tick();

        // Zero-step command.
        offer(1'b1, 0, 50);
        tick();
        cmd_valid = 1'b0;
        chk("t3_done", 32'(done), 32'h1);
        chk("t3_busy", 32'(busy), 32'h0);
        chk("t3_coil", 32'(coil), 32'h9);
        chk("t3_pos", position, 32'hFFFF_FFFD);
        tick();
        chk("t3_done_off", 32'(done), 32'h0);
        chk("t3_ready", 32'(cmd_ready), 32'h1);

        // Abort 10 clocks after the 5th step of a 20-step move.
        do_reset();
        offer(1'b1, 20, 50);
        tick();
        cmd_valid = 1'b0;
        ticks(250);
        chk("t4_pos5", position, 32'd5);
        chk("t4_coil5", 32'(coil), 32'h9);
        ticks(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        tick();
        chk("t4_ready", 32'(cmd_ready), 32'h1);
        chk("t4_done_off", 32'(done), 32'h0);
        ticks(60);
        chk("t4_no_step6", position, 32'd5);
        chk("t4_coil_held", 32'(coil), 32'h9);

        // cmd_valid held high across a 2-step move.
        offer(1'b1, 2, 50);
        tick();
        chk("t5_busy", 32'(busy), 32'h1);
        ticks(99);
        chk("t5_no_accept", 32'(cmd_ready), 32'h0);
        chk("t5_pos_mid", position, 32'd6);
        tick();
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_busy_off", 32'(busy), 32'h0);
        chk("t5_ready_done", 32'(cmd_ready), 32'h0);
        tick();
        chk("t5_idle_ready", 32'(cmd_ready), 32'h1);
        chk("t5_idle_busy", 32'(busy), 32'h0);
        tick();
        cmd_valid = 1'b0;
        chk("t5_second", 32'(busy), 32'h1);
        chk("t5_pos_first", position, 32'd7);
        ticks(100);
        chk("t5_done2", 32'(done), 32'h1);
        chk("t5_pos_second", position, 32'd9);
        tick();

        // Asynchronous reset mid-move.
        offer(1'b1, 10, 50);
        tick();
        cmd_valid = 1'b0;
        ticks(120);
        chk("t6_pos_pre", position, 32'd11);
        RSTN = 1'b0;
        #2;
        chk("t6_coil", 32'(coil), 32'h0);
        chk("t6_pos", position, 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_ready", 32'(cmd_ready), 32'h1);
        tick();
        RSTN = 1'b1;
        tick();
        chk("t6_coil_after", 32'(coil), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
